// File: rtl/instr_compressor.sv
// Dictionary-based instruction encoder: splits a 32-bit instruction into three fields,
// searches three streamed-in dictionaries in parallel and returns {key3,key2,key1}.
module instr_compressor #(
  parameter int FIELD1_VAL_WIDTH = 7,
  parameter int FIELD2_VAL_WIDTH = 10,
  parameter int FIELD3_VAL_WIDTH = 15,
  parameter int FIELD1_KEY_WIDTH = 3,
  parameter int FIELD2_KEY_WIDTH = 5,
  parameter int FIELD3_KEY_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        dict1_write_enable,
  input  logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  input  logic                        dict2_write_enable,
  input  logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  input  logic                        dict3_write_enable,
  input  logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_compressible,
  output logic [15:0]                 out_key,
  output logic [31:0]                 out_instr,
  output logic                        busy
);

  localparam int K1W = FIELD1_KEY_WIDTH;
  localparam int K2W = FIELD2_KEY_WIDTH;
  localparam int K3W = FIELD3_KEY_WIDTH;
  localparam int C1W = K1W + 1;
  localparam int C2W = K2W + 1;
  localparam int C3W = K3W + 1;
  localparam int IW  = K3W + 1;
  localparam logic [C1W-1:0] FULL1 = C1W'(1 << K1W);
  localparam logic [C2W-1:0] FULL2 = C2W'(1 << K2W);
  localparam logic [C3W-1:0] FULL3 = C3W'(1 << K3W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [FIELD1_VAL_WIDTH-1:0] dict1_q [1 << K1W];
  logic [FIELD2_VAL_WIDTH-1:0] dict2_q [1 << K2W];
  logic [FIELD3_VAL_WIDTH-1:0] dict3_q [1 << K3W];

  logic [C1W-1:0] cnt1_q;
  logic [C2W-1:0] cnt2_q;
  logic [C3W-1:0] cnt3_q;
  logic [IW-1:0]  idx_q, idx_d;
  logic           found1_q, found1_d, found2_q, found2_d, found3_q, found3_d;
  logic [K1W-1:0] key1_q, key1_d;
  logic [K2W-1:0] key2_q, key2_d;
  logic [K3W-1:0] key3_q, key3_d;
  logic [31:0]    instr_q, instr_d;
  logic           comp_q, comp_d;
  logic [15:0]    okey_q, okey_d;

  logic           wr1_s, wr2_s, wr3_s;
  logic           hit1_s, hit2_s, hit3_s;
  logic           all_found_s, last_idx_s;
  logic [IW-1:0]  max_cnt_s;
  logic [FIELD1_VAL_WIDTH-1:0] f1_s;
  logic [FIELD2_VAL_WIDTH-1:0] f2_s;
  logic [FIELD3_VAL_WIDTH-1:0] f3_s;

  assign f1_s = instr_q[FIELD1_VAL_WIDTH-1:0];
  assign f2_s = instr_q[FIELD1_VAL_WIDTH +: FIELD2_VAL_WIDTH];
  assign f3_s = instr_q[FIELD1_VAL_WIDTH+FIELD2_VAL_WIDTH +: FIELD3_VAL_WIDTH];

  // Loading only happens in IDLE and stops once a dictionary is full
  assign wr1_s = (state_q == ST_IDLE) && dict1_write_enable && (cnt1_q != FULL1);
  assign wr2_s = (state_q == ST_IDLE) && dict2_write_enable && (cnt2_q != FULL2);
  assign wr3_s = (state_q == ST_IDLE) && dict3_write_enable && (cnt3_q != FULL3);

  assign in_ready = (state_q == ST_IDLE) &&
                    !(dict1_write_enable || dict2_write_enable || dict3_write_enable);

  assign hit1_s = !found1_q && (idx_q < IW'(cnt1_q)) && (dict1_q[idx_q[K1W-1:0]] == f1_s);
  assign hit2_s = !found2_q && (idx_q < IW'(cnt2_q)) && (dict2_q[idx_q[K2W-1:0]] == f2_s);
  assign hit3_s = !found3_q && (idx_q < IW'(cnt3_q)) && (dict3_q[idx_q[K3W-1:0]] == f3_s);

  assign all_found_s = (found1_q | hit1_s) & (found2_q | hit2_s) & (found3_q | hit3_s);

  // Largest loaded count bounds the search; max of zero exits after one cycle
  always_comb begin
    max_cnt_s = IW'(cnt3_q);
    if (IW'(cnt2_q) > max_cnt_s) begin
      max_cnt_s = IW'(cnt2_q);
    end else begin
      max_cnt_s = max_cnt_s;
    end
    if (IW'(cnt1_q) > max_cnt_s) begin
      max_cnt_s = IW'(cnt1_q);
    end else begin
      max_cnt_s = max_cnt_s;
    end
  end

  assign last_idx_s = (idx_q + IW'(1)) >= max_cnt_s;

  // Next-state and search datapath
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    found1_d = found1_q;
    found2_d = found2_q;
    found3_d = found3_q;
    key1_d   = key1_q;
    key2_d   = key2_q;
    key3_d   = key3_q;
    instr_d  = instr_q;
    comp_d   = comp_q;
    okey_d   = okey_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = ST_SEARCH;
          instr_d  = in_instr;
          idx_d    = '0;
          found1_d = 1'b0;
          found2_d = 1'b0;
          found3_d = 1'b0;
          key1_d   = '0;
          key2_d   = '0;
          key3_d   = '0;
          comp_d   = 1'b0;
          okey_d   = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        found1_d = found1_q | hit1_s;
        found2_d = found2_q | hit2_s;
        found3_d = found3_q | hit3_s;
        key1_d   = hit1_s ? idx_q[K1W-1:0] : key1_q;
        key2_d   = hit2_s ? idx_q[K2W-1:0] : key2_q;
        key3_d   = hit3_s ? idx_q[K3W-1:0] : key3_q;
        if (all_found_s || last_idx_s) begin
          state_d = ST_DONE;
          comp_d  = all_found_s;
          okey_d  = all_found_s ? 16'({key3_d, key2_d, key1_d}) : 16'h0000;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, search and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      found1_q <= 1'b0;
      found2_q <= 1'b0;
      found3_q <= 1'b0;
      key1_q   <= '0;
      key2_q   <= '0;
      key3_q   <= '0;
      instr_q  <= 32'h0000_0000;
      comp_q   <= 1'b0;
      okey_q   <= 16'h0000;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      cnt3_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      found1_q <= found1_d;
      found2_q <= found2_d;
      found3_q <= found3_d;
      key1_q   <= key1_d;
      key2_q   <= key2_d;
      key3_q   <= key3_d;
      instr_q  <= instr_d;
      comp_q   <= comp_d;
      okey_q   <= okey_d;
      if (wr1_s) cnt1_q <= cnt1_q + C1W'(1);
      if (wr2_s) cnt2_q <= cnt2_q + C2W'(1);
      if (wr3_s) cnt3_q <= cnt3_q + C3W'(1);
    end
  end

  // Entry storage is deliberately unreset; counts gate every read
  always_ff @(posedge clk) begin
    if (wr1_s) dict1_q[cnt1_q[K1W-1:0]] <= dict1_write_val;
    if (wr2_s) dict2_q[cnt2_q[K2W-1:0]] <= dict2_write_val;
    if (wr3_s) dict3_q[cnt3_q[K3W-1:0]] <= dict3_write_val;
  end

  assign out_valid        = (state_q == ST_DONE);
  assign busy             = (state_q != ST_IDLE);
  assign out_compressible = comp_q;
  assign out_key          = okey_q;
  assign out_instr        = instr_q;

endmodule

// File: tb/tb_instr_compressor.sv
// Scoreboard bench for instr_compressor: directed encodes with hand-computed keys and latencies.
module tb_instr_compressor;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        d1_we = 1'b0, d2_we = 1'b0, d3_we = 1'b0;
  logic [6:0]  d1_v = 7'h00;
  logic [9:0]  d2_v = 10'h000;
  logic [14:0] d3_v = 15'h0000;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        out_valid, out_ready = 1'b1, out_compressible, busy;
  logic [15:0] out_key;
  logic [31:0] out_instr;

  instr_compressor dut (
    .clk(clk), .resetn(resetn),
    .dict1_write_enable(d1_we), .dict1_write_val(d1_v),
    .dict2_write_enable(d2_we), .dict2_write_val(d2_v),
    .dict3_write_enable(d3_we), .dict3_write_val(d3_v),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_compressible(out_compressible), .out_key(out_key),
    .out_instr(out_instr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        comp;
    logic [15:0] key;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: track acceptances, compare DUT results against the head of the scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (acc_q.size() == 0) chk("latency_no_accept", 32'd0, 32'd1);
            else chk("latency", cyc - acc_q[0], sb[0].lat);
          end
          chk("out_compressible", {31'd0, out_compressible}, {31'd0, sb[0].comp});
          chk("out_key", {16'd0, out_key}, {16'd0, sb[0].key});
          chk("out_instr", out_instr, sb[0].instr);
          if (out_ready) begin
            void'(sb.pop_front());
            if (acc_q.size() != 0) void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] f1, input logic [9:0] f2, input logic [14:0] f3);
    return {f3, f2, f1};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic wr(input int d, input logic [14:0] v);
    case (d)
      1: begin d1_we = 1'b1; d1_v = v[6:0]; end
      2: begin d2_we = 1'b1; d2_v = v[9:0]; end
      default: begin d3_we = 1'b1; d3_v = v; end
    endcase
    @(posedge clk); #1;
    d1_we = 1'b0; d2_we = 1'b0; d3_we = 1'b0;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("result_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    #1;
  endtask

  task automatic encode(input logic [31:0] ins, input logic comp, input logic [15:0] key, input int lat);
    exp_t e;
    e.instr = ins; e.comp = comp; e.key = key; e.lat = lat;
    sb.push_back(e);
    in_valid = 1'b1;
    in_instr = ins;
    wait_accept();
    wait_drain();
  endtask

  initial begin
    exp_t e;
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_comp", {31'd0, out_compressible}, 32'd0);
    chk("rst_out_key", {16'd0, out_key}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-SEARCH, then encode with empty dictionaries
    for (int i = 0; i < 10; i++) wr(3, 15'(i));
    in_valid = 1'b1;
    in_instr = mk(7'h13, 10'h001, 15'h7000);
    wait_accept();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    encode(mk(7'h13, 10'h001, 15'h0050), 1'b0, 16'h0000, 1);

    // Basic dictionaries
    do_reset();
    wr(1, 15'h33); wr(1, 15'h13);
    wr(2, 15'h001);
    wr(3, 15'h000); wr(3, 15'h000); wr(3, 15'h050);
    encode(32'h00A00093, 1'b1, 16'h0201, 3);
    encode(32'h00A00013, 1'b0, 16'h0000, 3);

    // Saturation of dict1 and worst-case dict3 search
    do_reset();
    for (int i = 1; i <= 9; i++) wr(1, 15'(i));
    wr(2, 15'h3FF);
    for (int i = 0; i < 255; i++) wr(3, 15'(i));
    wr(3, 15'h7ABC);
    encode(mk(7'h05, 10'h3FF, 15'h7ABC), 1'b1, 16'hFF04, 256);
    encode(mk(7'h09, 10'h3FF, 15'h7ABC), 1'b0, 16'h0000, 256);

    // Duplicates, held outputs and writes dropped in DONE
    do_reset();
    wr(1, 15'h33); wr(1, 15'h13); wr(1, 15'h20); wr(1, 15'h21); wr(1, 15'h13);
    wr(2, 15'h001);
    wr(3, 15'h050);
    out_ready = 1'b0;
    e.instr = 32'h00A00093; e.comp = 1'b1; e.key = 16'h0001; e.lat = 2;
    sb.push_back(e);
    in_valid = 1'b1;
    in_instr = 32'h00A00093;
    wait_accept();
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      d1_we = 1'b1; d1_v = 7'h7F;
      d2_we = 1'b1; d2_v = 10'h2AA;
      d3_we = 1'b1; d3_v = 15'h1234;
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    d1_we = 1'b0; d2_we = 1'b0; d3_we = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    encode(mk(7'h7F, 10'h001, 15'h0050), 1'b0, 16'h0000, 5);

    // Write simultaneous with in_valid wins; instruction accepted afterwards
    do_reset();
    wr(1, 15'h33);
    wr(2, 15'h001);
    wr(3, 15'h050);
    e.instr = 32'h00A00093; e.comp = 1'b1; e.key = 16'h0001; e.lat = 2;
    sb.push_back(e);
    in_valid = 1'b1;
    in_instr = 32'h00A00093;
    d1_we = 1'b1; d1_v = 7'h13;
    @(negedge clk);
    chk("wr_blocks_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    d1_we = 1'b0;
    wait_accept();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
